// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle 32-bit multiply/divide unit with architectural HI/LO registers.
// One bit per clock over 32 iterations: shift-add multiply and restoring divide.
// The operation starts with a launch edge, runs 32 iterations, then takes one fix-up edge.
// Hi/Lo are written only on the fix-up edge, on a direct write, or on reset.
//
// Configuration macro: MDU_DIV_EN. When it is defined, the divider is built.
// When it is undefined, the divider is removed and a Start with op[1] = 1 is ignored.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   launch request, sampled only in IDLE
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     in   multiplicand/dividend, multiplier/divisor
//   wr_hi    in   direct write of hi (IDLE only)
//   wr_lo    in   direct write of lo (IDLE only)
//   wr_data  in   data for wr_hi/wr_lo
//   busy     out  operation in flight (registered)
//   done     out  one-cycle pulse when hi/lo hold a new result (registered)
//   hi, lo   out  architectural HI/LO registers
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;   // multiply: {partial sum, multiplier}; divide: {remainder, quotient}
  logic [31:0] opnd_q;  // multiplicand or divisor magnitude
  logic        neg_q;   // negate product / quotient in FIX

  logic        is_signed;
  logic        launch;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;

  always_comb begin
    is_signed = ~op[0];
    a_abs     = (is_signed && a[31]) ? 32'd0 - a : a;
    b_abs     = (is_signed && b[31]) ? 32'd0 - b : b;
`ifdef MDU_DIV_EN
    launch    = start;
`else
    launch    = start & ~op[1];
`endif
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    prod_fix  = neg_q ? 64'd0 - acc_q : acc_q;
  end

`ifdef MDU_DIV_EN
  logic        div_q;
  logic        dz_q;      // divide by zero: acc preloaded with the final result, held in RUN
  logic        rem_neg_q;
  logic        b_zero;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    b_zero    = (b == 32'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    // The remainder is less than the divisor, so a negative difference always shows in bit 32.
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    quo_fix   = neg_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];
    rem_fix   = rem_neg_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
`ifdef MDU_DIV_EN
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            state_q <= StRun;
            busy    <= 1'b1;
            cnt_q   <= 5'd0;
`ifdef MDU_DIV_EN
            div_q   <= op[1];
            if (op[1]) begin
              dz_q      <= b_zero;
              acc_q     <= b_zero ? {a, 32'hFFFF_FFFF} : {32'd0, a_abs};
              opnd_q    <= b_abs;
              neg_q     <= is_signed & (a[31] ^ b[31]) & ~b_zero;
              rem_neg_q <= is_signed & a[31] & ~b_zero;
            end else begin
              dz_q      <= 1'b0;
              acc_q     <= {32'd0, b_abs};
              opnd_q    <= a_abs;
              neg_q     <= is_signed & (a[31] ^ b[31]);
              rem_neg_q <= 1'b0;
            end
`else
            acc_q   <= {32'd0, b_abs};
            opnd_q  <= a_abs;
            neg_q   <= is_signed & (a[31] ^ b[31]);
`endif
          end else begin
            // Start takes priority; a write in the same cycle is discarded.
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        StRun: begin
`ifdef MDU_DIV_EN
          if (!div_q)     acc_q <= mul_next;
          else if (!dz_q) acc_q <= div_next;
`else
          acc_q <= mul_next;
`endif
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFix;
        end
        StFix: begin
`ifdef MDU_DIV_EN
          if (div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
`else
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
`endif
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb[$];

  mult_div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        res_t r;
        r = sb.pop_front();
        check_eq("hi", {32'd0, hi}, {32'd0, r.hi});
        check_eq("lo", {32'd0, lo}, {32'd0, r.lo});
      end
    end
  end

  // mode 0: plain; 1: start+wr_hi pulsed mid-run; 2: wr_lo together with start
  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] eh, input logic [31:0] el, input int mode);
    logic [31:0] hb, lb;
    int n, busy_n;
    res_t r;
    @(negedge clk);
    hb = hi;
    lb = lo;
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    if (mode == 2) begin
      wr_lo = 1'b1;
      wr_data = 32'h1234_5678;
    end
    r.hi = eh;
    r.lo = el;
    sb.push_back(r);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (n == 1) begin
        start = 1'b0;
        wr_lo = 1'b0;
        a = 32'h0BAD_0BAD;
        b = 32'h0;
        if (mode == 2) check_eq("start_beats_wr", {hi, lo}, {hb, lb});
      end
      if (mode == 1 && n == 5) begin
        start = 1'b1;
        wr_hi = 1'b1;
        wr_data = 32'hDEAD_BEEF;
      end
      if (mode == 1 && n == 6) begin
        start = 1'b0;
        wr_hi = 1'b0;
      end
      if (mode == 1 && n == 7) check_eq("wr_while_busy", {32'd0, hi}, {32'd0, hb});
    end while (!done && n < 100);
    check_eq("done_latency", n, 34);
    check_eq("busy_cycles", busy_n, 33);
    @(negedge clk);
    check_eq("done_pulse", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hb, lb;
    bit saw;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wr_data = 32'd0;
    #23;
    check_eq("reset_state", {busy, done, 30'd0, hi ^ lo, 32'd0} | {32'd0, hi | lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);

    // Direct writes
    @(negedge clk);
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wr_data = 32'hA5A5_0F0F;
    @(negedge clk);
    check_eq("wr_both", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    wr_hi = 1'b0;
    wr_data = 32'd5;
    @(negedge clk);
    check_eq("wr_lo", {hi, lo}, {32'hA5A5_0F0F, 32'd5});
    wr_lo = 1'b0;

`ifdef MDU_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0);
`else
    hb = hi;
    lb = lo;
    @(negedge clk);
    start = 1'b1;
    op = 2'b10;
    a = 32'd9;
    b = 32'd3;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) saw = 1'b1;
    end
    check_eq("nodiv_ignored", {63'd0, saw}, 64'd0);
    check_eq("nodiv_hilo", {hi, lo}, {hb, lb});
`endif

    run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 0);

    // Reset mid-run: aborts without a result
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("busy_mid_run", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_hilo", {hi, lo}, 64'd0);
    check_eq("abort_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle 32-bit multiply/divide unit with architectural HI/LO registers for the datapath's execute stage. It iterates one bit per clock over 32 cycles, using shift-add for multiply and restoring division for divide, and handshakes with the control unit through Start/Busy/Done. Hi and Lo feed the 32-bit Mux2to1 instances that select the write-back value, either ALU result vs. Hi or ALU result vs. Lo, so both outputs must be stable whenever Busy is low.

## Interface
- No parameters; data width fixed at 32.
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  launch operation; sampled only in IDLE.
- Op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- A, B  in  32 each, signed  operands; A is multiplicand/dividend, B is multiplier/divisor.
- WrHi, WrLo  in  1 each  direct register writes (mthi/mtlo).
- WrData  in  32  data for WrHi/WrLo.
- Busy  out  1  high while an operation is in flight.
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result.
- Hi, Lo  out  32 each, signed  architectural HI/LO registers.

## Operation
- FSM has three states: IDLE, RUN, FIX.
  - IDLE → RUN when Start is high.
  - RUN → FIX after 32 iterations (5-bit counter reaches 31).
  - FIX → IDLE unconditionally.
- Launch edge:
  - Latch |A|, |B| for signed ops; raw A, B for unsigned ops.
  - Latch sign flags: product/quotient sign = A[31]^B[31]; remainder sign = A[31]; both forced to 0 for unsigned ops.
- Multiply:
  - 64-bit accumulator; each RUN cycle: if multiplier LSB is set, add the multiplicand to the upper half; then shift right one bit.
- Divide:
  - 33-bit partial remainder; each RUN cycle: shift in the next dividend bit, trial-subtract the divisor, and keep the result if it is non-negative.
  - Quotient bit = 1 when the subtraction is kept.
- FIX state:
  - Apply two's-complement negation per the sign flags.
  - Write Hi/Lo: for multiply, Hi = product[63:32], Lo = product[31:0]; for divide, Lo = quotient, Hi = remainder.
- Divide by zero: Lo = 32'hFFFF_FFFF, Hi = A, with no sign fix. Done pulses normally.
- Signed overflow: 32'h8000_0000 / 32'hFFFF_FFFF gives Lo = 32'h8000_0000, Hi = 0.
- Register writes:
  - WrHi/WrLo update the register on the next edge, in IDLE only.
  - Writes while Busy are ignored.
  - Start together with WrHi/WrLo in IDLE: Start wins and the write is discarded.
  - WrHi and WrLo together: both registers are written.
- Start while Busy is ignored; it is not queued.

## Timing
- Reset values: Busy = 0, Done = 0, Hi = 0, Lo = 0, state = IDLE, counter = 0.
- Rst_n low at any time, including mid-RUN, aborts immediately with the values above. No result is written.
- Edge 0 samples Start; Busy is high from edge 0 until edge 33.
  - Edges 1–32: iterations.
  - Edge 33: FIX writes Hi/Lo, sets Done = 1, returns to IDLE.
- Done is high for exactly the one cycle after edge 33. Hi/Lo are valid from that cycle onward.
- Earliest next Start is sampled at edge 34 (the Done cycle): 34-cycle issue interval.
- Hi/Lo change only at the FIX edge, on a WrHi/WrLo edge, or on reset. They are never changed by intermediate iteration state.
- Busy and Done are registered outputs; there is no combinational path from inputs to outputs.

## Configuration
- MDU_DIV_EN defined: the full unit, with all four Op codes supported as above.
- MDU_DIV_EN undefined:
  - Divider datapath removed.
  - Start with Op[1] = 1 is ignored: no Busy, no Done, Hi/Lo unchanged.
  - Multiply timing and behaviour are identical to the defined build.

## Test plan
- MULT, A = 32'hFFFF_FFFD (−3), B = 7 → Done one cycle after edge 33; Hi = 32'hFFFF_FFFF, Lo = 32'hFFFF_FFEB; Busy high for exactly 33 cycles.
- MULTU, A = B = 32'hFFFF_FFFF → Hi = 32'hFFFF_FFFE, Lo = 32'h0000_0001.
- DIV, A = −7, B = 2 → Lo = 32'hFFFF_FFFD, Hi = 32'hFFFF_FFFF.
  - Then DIVU, A = 7, B = 0 → Lo = 32'hFFFF_FFFF, Hi = 7.
- DIV, A = 32'h8000_0000, B = 32'hFFFF_FFFF → Lo = 32'h8000_0000, Hi = 0.
- Handshake and reset sequence:
  - WrLo = 1, WrData = 5 in IDLE → Lo = 5 next edge.
  - During RUN, pulse Start and WrHi → both ignored; the in-flight result is unaffected.
  - Assert Rst_n low at iteration 10 → Hi/Lo/Busy/Done = 0 at once.
  - After release, MULTU 3×4 → Lo = 12, Hi = 0.
- Build without MDU_DIV_EN: Start with Op = 10 → Busy stays 0, no Done, Hi/Lo unchanged. A subsequent MULT 2×3 → Lo = 6.
